multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore-style main control FSM that sequences the 32-bit multi-cycle datapath. It sits beside the datapath, takes the 6-bit opcode from the instruction register, and drives every datapath control input.
- It steps each instruction through fetch, decode, execute, memory and write-back states. All datapath registers are fed only through the enables this block generates.

Parameters:
- ALU_ADD, 3'b000, ALUSelect code for add.
- ALU_SUB, 3'b001, ALUSelect code for subtract (used by branch compare).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Opcode  in  6  instruction opcode from the instruction register.
- PCWrite, PCWriteCond, MemWrite, MemAddr, IRWrite, ALUSrcA, RegRead, RegWrite  out  1 each  datapath controls.
- PCSource, ALUSrcB, MemtoReg, BranchCond  out  2 each  datapath mux selects.
- ALUSelect  out  3  ALU operation.
- Halted  out  1  high while in HALT.
- Illegal  out  1  one-cycle pulse in DECODE on an unknown opcode.
- State  out  4  current state encoding, for debug.

Behaviour:
- Opcode map:
  - 000xxx: R-type, R1 = R2 op R3, ALUSelect = op[2:0].
  - 010xxx: I-type, R1 = R2 op ZE16, ALUSelect = op[2:0].
  - 100000 LI: R1 = ZE16.
  - 100001 LUI: R1 = Imm<<16.
  - 100010 LWI: R1 = M[ZE16].
  - 100011 SWI: M[ZE16] = R1.
  - 100100 LW: R1 = M[R2+SE16].
  - 100101 SW: M[R2+SE16] = R1.
  - 1100cc: branch on R2-R1, BranchCond = cc (0 bne, 1 beq, 2 blt, 3 ble).
  - 111000 J.
  - 111111 HALT.
  - Any other opcode is illegal.
- States: FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, LI_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT.
- Default for every output in every state is 0, except RegRead.
- RegRead = 1 whenever Opcode is SWI, SW or a branch, in every state, so RegB holds R1.
- Per-state outputs and transitions:
  - FETCH: IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUSelect=ALU_ADD, PCSource=0, PCWrite=1. Next state DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=2, ALU_ADD, so ALUOut = PC+1+SE16 (branch target). Next state by opcode class; illegal opcode returns to FETCH with Illegal=1.
  - EXEC_R: ALUSrcA=1, ALUSrcB=0, ALUSelect=op[2:0]. Next ALU_WB.
  - EXEC_I: ALUSrcA=1, ALUSrcB=3, ALUSelect=op[2:0]. Next ALU_WB.
  - ALU_WB: repeats the EXEC ALU selects, MemtoReg=0, RegWrite=1. Next FETCH.
  - LI_WB: MemtoReg=1 (LI) or 3 (LUI), RegWrite=1. Next FETCH.
  - MEM_ADDR (LW/SW): ALUSrcA=1, ALUSrcB=2, ALU_ADD. Next MEM_RD for LW, MEM_WR for SW.
  - MEM_RD: holds MEM_ADDR ALU selects so ALUOut stays stable; MemAddr=1 for LWI, 0 for LW. Next MEM_WB.
  - MEM_WB: MemtoReg=2, RegWrite=1. Next FETCH.
  - MEM_WR: MemWrite=1. MemAddr=1 for SWI; for SW, MemAddr=0 with the MEM_ADDR ALU selects held. Next FETCH.
  - DECODE routes LWI directly to MEM_RD and SWI directly to MEM_WR.
  - BRANCH: ALUSrcA=1, ALUSrcB=0, ALU_SUB, PCWriteCond=1, PCSource=1, BranchCond=op[1:0]. Next FETCH.
  - JUMP: PCSource=2, PCWrite=1. Next FETCH.
  - HALT: all outputs 0 except Halted=1. Stays in HALT until Reset.
- Cycles per instruction:
  - R/I: 4.
  - LI/LUI/SWI/BRANCH/J: 3.
  - LWI/SW: 4.
  - LW: 5.
- Reset:
  - While Reset=1, all write enables (PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite) are forced 0 combinationally.
  - Selects, Halted and Illegal are also 0.
  - On a clock edge with Reset=1, State goes to FETCH; FETCH outputs begin the cycle after Reset falls.
  - Reset asserted mid-instruction aborts it with no register or memory write in that cycle. Reset overrides HALT.
- Opcode is sampled for transitions only in DECODE. Later states use Opcode as held by the IR; IRWrite=0 guarantees it is stable.
- State encoding is fixed and exported on State: FETCH=0 … HALT=12, in the listed order.

Test Plan:
- Reset held 3 cycles, then released with Opcode=000000 → all enables 0 during reset; sequence FETCH, DECODE, EXEC_R, ALU_WB, FETCH; RegWrite=1 only in cycle 4, ALUSelect=000.
- Opcode=100100 (LW) → 5 states; MemAddr=0, MemtoReg=2 and RegWrite=1 in MEM_WB; ALUSrcB=2 held constant across MEM_ADDR and MEM_RD.
- Opcode=100011 (SWI) → FETCH, DECODE, MEM_WR; MemWrite=1 and MemAddr=1 for exactly one cycle; RegRead=1 throughout.
- Opcode=110010 (blt) → BRANCH cycle with PCWriteCond=1, BranchCond=2, PCSource=1, ALUSelect=ALU_SUB, PCWrite=0.
- Opcode=101111 (illegal) → Illegal pulses for 1 cycle in DECODE; next state FETCH; no write enable asserted.
- Opcode=111111 → Halted=1 and all enables 0 for 20 cycles; Reset=1 for one cycle → State=FETCH and Halted=0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle control FSM and the 32-bit datapath.
// The control unit takes the master side; the datapath takes the slave side.
interface multicycle_control_if;
    logic [5:0] Opcode;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       MemWrite;
    logic       MemAddr;
    logic       IRWrite;
    logic       ALUSrcA;
    logic       RegRead;
    logic       RegWrite;

    logic [1:0] PCSource;
    logic [1:0] ALUSrcB;
    logic [1:0] MemtoReg;
    logic [1:0] BranchCond;
    logic [2:0] ALUSelect;

    logic       Halted;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  Opcode,
        output PCWrite,
        output PCWriteCond,
        output MemWrite,
        output MemAddr,
        output IRWrite,
        output ALUSrcA,
        output RegRead,
        output RegWrite,
        output PCSource,
        output ALUSrcB,
        output MemtoReg,
        output BranchCond,
        output ALUSelect,
        output Halted,
        output Illegal,
        output State
    );

    modport slave (
        output Opcode,
        input  PCWrite,
        input  PCWriteCond,
        input  MemWrite,
        input  MemAddr,
        input  IRWrite,
        input  ALUSrcA,
        input  RegRead,
        input  RegWrite,
        input  PCSource,
        input  ALUSrcB,
        input  MemtoReg,
        input  BranchCond,
        input  ALUSelect,
        input  Halted,
        input  Illegal,
        input  State
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle datapath: steps each instruction through
// fetch/decode/execute/memory/write-back and drives every datapath control.
module multicycle_control #(
    parameter logic [2:0] ALU_ADD = 3'b000,
    parameter logic [2:0] ALU_SUB = 3'b001
) (
    input  logic                Clk,
    input  logic                Reset,
    multicycle_control_if.master ctl
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] EXEC_R   = 4'd2;
    localparam logic [3:0] EXEC_I   = 4'd3;
    localparam logic [3:0] ALU_WB   = 4'd4;
    localparam logic [3:0] LI_WB    = 4'd5;
    localparam logic [3:0] MEM_ADDR = 4'd6;
    localparam logic [3:0] MEM_RD   = 4'd7;
    localparam logic [3:0] MEM_WB   = 4'd8;
    localparam logic [3:0] MEM_WR   = 4'd9;
    localparam logic [3:0] BRANCH   = 4'd10;
    localparam logic [3:0] JUMP     = 4'd11;
    localparam logic [3:0] HALT     = 4'd12;

    logic [3:0] state_reg;
    logic [3:0] state_next;

    // Opcode classification
    logic is_rtype;
    logic is_itype;
    logic is_li;
    logic is_lui;
    logic is_lwi;
    logic is_swi;
    logic is_lw;
    logic is_sw;
    logic is_branch;
    logic is_jump;
    logic is_halt;
    logic is_legal;

    always_comb begin
        is_rtype  = (ctl.Opcode[5:3] == 3'b000);
        is_itype  = (ctl.Opcode[5:3] == 3'b010);
        is_li     = (ctl.Opcode == 6'b100000);
        is_lui    = (ctl.Opcode == 6'b100001);
        is_lwi    = (ctl.Opcode == 6'b100010);
        is_swi    = (ctl.Opcode == 6'b100011);
        is_lw     = (ctl.Opcode == 6'b100100);
        is_sw     = (ctl.Opcode == 6'b100101);
        is_branch = (ctl.Opcode[5:2] == 4'b1100);
        is_jump   = (ctl.Opcode == 6'b111000);
        is_halt   = (ctl.Opcode == 6'b111111);
        is_legal  = is_rtype | is_itype | is_li | is_lui | is_lwi | is_swi |
                    is_lw | is_sw | is_branch | is_jump | is_halt;
    end

    // Next-state logic; the opcode only steers the flow out of DECODE and
    // the MEM_ADDR split, where the IR is guaranteed stable.
    always_comb begin
        state_next = FETCH;
        case (state_reg)
            FETCH:  state_next = DECODE;
            DECODE: begin
                if (is_rtype)                 state_next = EXEC_R;
                else if (is_itype)            state_next = EXEC_I;
                else if (is_li || is_lui)     state_next = LI_WB;
                else if (is_lwi)              state_next = MEM_RD;
                else if (is_swi)              state_next = MEM_WR;
                else if (is_lw || is_sw)      state_next = MEM_ADDR;
                else if (is_branch)           state_next = BRANCH;
                else if (is_jump)             state_next = JUMP;
                else if (is_halt)             state_next = HALT;
                else                          state_next = FETCH;
            end
            EXEC_R:   state_next = ALU_WB;
            EXEC_I:   state_next = ALU_WB;
            ALU_WB:   state_next = FETCH;
            LI_WB:    state_next = FETCH;
            MEM_ADDR: state_next = is_lw ? MEM_RD : MEM_WR;
            MEM_RD:   state_next = MEM_WB;
            MEM_WB:   state_next = FETCH;
            MEM_WR:   state_next = FETCH;
            BRANCH:   state_next = FETCH;
            JUMP:     state_next = FETCH;
            HALT:     state_next = HALT;
            default:  state_next = FETCH;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Per-state control values before reset gating
    logic       pc_write;
    logic       pc_write_cond;
    logic       mem_write;
    logic       mem_addr;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_read;
    logic       reg_write;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] mem_to_reg;
    logic [1:0] branch_cond;
    logic [2:0] alu_select;
    logic       halted;
    logic       illegal;

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_write     = 1'b0;
        mem_addr      = 1'b0;
        ir_write      = 1'b0;
        alu_src_a     = 1'b0;
        reg_write     = 1'b0;
        pc_source     = 2'd0;
        alu_src_b     = 2'd0;
        mem_to_reg    = 2'd0;
        branch_cond   = 2'd0;
        alu_select    = ALU_ADD;
        halted        = 1'b0;
        illegal       = 1'b0;
        // Keeps RegB loaded with R1 for stores and branch compares
        reg_read      = is_swi | is_sw | is_branch;

        case (state_reg)
            FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'd1;
                alu_select = ALU_ADD;
                pc_write   = 1'b1;
            end
            DECODE: begin
                alu_src_b  = 2'd2;
                alu_select = ALU_ADD;
                illegal    = ~is_legal;
            end
            EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd0;
                alu_select = ctl.Opcode[2:0];
            end
            EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd3;
                alu_select = ctl.Opcode[2:0];
            end
            ALU_WB: begin
                alu_src_a  = 1'b1;
                alu_src_b  = is_itype ? 2'd3 : 2'd0;
                alu_select = ctl.Opcode[2:0];
                mem_to_reg = 2'd0;
                reg_write  = 1'b1;
            end
            LI_WB: begin
                mem_to_reg = is_lui ? 2'd3 : 2'd1;
                reg_write  = 1'b1;
            end
            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                alu_select = ALU_ADD;
            end
            MEM_RD: begin
                // ALU selects held so ALUOut keeps the effective address
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                alu_select = ALU_ADD;
                mem_addr   = is_lwi;
            end
            MEM_WB: begin
                mem_to_reg = 2'd2;
                reg_write  = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                if (is_swi) begin
                    mem_addr = 1'b1;
                end else begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'd2;
                    alu_select = ALU_ADD;
                end
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'd0;
                alu_select    = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
                branch_cond   = ctl.Opcode[1:0];
            end
            JUMP: begin
                pc_source = 2'd2;
                pc_write  = 1'b1;
            end
            HALT: begin
                halted   = 1'b1;
                reg_read = 1'b0;
            end
            default: ;
        endcase
    end

    // Reset suppresses every write and select in the same cycle, so an
    // aborted instruction never commits a register or memory write.
    always_comb begin
        ctl.RegRead = reg_read;
        ctl.State   = state_reg;
        if (Reset) begin
            ctl.PCWrite     = 1'b0;
            ctl.PCWriteCond = 1'b0;
            ctl.MemWrite    = 1'b0;
            ctl.MemAddr     = 1'b0;
            ctl.IRWrite     = 1'b0;
            ctl.ALUSrcA     = 1'b0;
            ctl.RegWrite    = 1'b0;
            ctl.PCSource    = 2'd0;
            ctl.ALUSrcB     = 2'd0;
            ctl.MemtoReg    = 2'd0;
            ctl.BranchCond  = 2'd0;
            ctl.ALUSelect   = 3'd0;
            ctl.Halted      = 1'b0;
            ctl.Illegal     = 1'b0;
        end else begin
            ctl.PCWrite     = pc_write;
            ctl.PCWriteCond = pc_write_cond;
            ctl.MemWrite    = mem_write;
            ctl.MemAddr     = mem_addr;
            ctl.IRWrite     = ir_write;
            ctl.ALUSrcA     = alu_src_a;
            ctl.RegWrite    = reg_write;
            ctl.PCSource    = pc_source;
            ctl.ALUSrcB     = alu_src_b;
            ctl.MemtoReg    = mem_to_reg;
            ctl.BranchCond  = branch_cond;
            ctl.ALUSelect   = alu_select;
            ctl.Halted      = halted;
            ctl.Illegal     = illegal;
        end
    end

endmodule
